// File: rtl/lcd_nibble_receiver.sv
// Passive HD44780 bus snooper: rebuilds bytes from 4-bit or init-time 8-bit strobes
// and mirrors the 2x16 character display into a local buffer with a registered read port.
module lcd_nibble_receiver (
    input  logic       clkLcd,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_e,
    input  logic [3:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic       mode4,
    output logic       busy,
    output logic [4:0] cur_addr,
    output logic       overrun
);

    localparam logic PH_HIGH = 1'b0;
    localparam logic PH_LOW  = 1'b1;

    logic       e_q;
    logic       rs_q;
    logic [3:0] d_q;
    logic       phase;
    logic [3:0] hi_nib;
    logic       hi_rs;
    logic [4:0] sweep_idx;
    logic [7:0] disp_buf [32];

    logic       strobe;
    logic       comp_valid;
    logic       comp_rs;
    logic [7:0] comp_byte;

    // Falling edge of E, seen against the registered copy of the bus.
    always_comb begin
        strobe     = e_q & ~lcd_e;
        comp_valid = 1'b0;
        comp_rs    = rs_q;
        comp_byte  = {d_q, 4'h0};
        if (strobe) begin
            if (!mode4) begin
                comp_valid = 1'b1;
            end else if (phase == PH_LOW) begin
                comp_valid = 1'b1;
                comp_rs    = hi_rs;
                comp_byte  = {hi_nib, d_q};
            end
        end
    end

    always_ff @(posedge clkLcd or posedge reset) begin
        if (reset) begin
            e_q    <= 1'b0;
            rs_q   <= 1'b0;
            d_q    <= '0;
            mode4  <= 1'b0;
            phase  <= PH_HIGH;
            hi_nib <= '0;
            hi_rs  <= 1'b0;
        end else begin
            e_q  <= lcd_e;
            rs_q <= lcd_rs;
            d_q  <= lcd_data;
            if (strobe) begin
                if (!mode4) begin
                    if (!rs_q && d_q == 4'h2) begin
                        mode4 <= 1'b1;
                        phase <= PH_HIGH;
                    end
                end else if (phase == PH_HIGH) begin
                    hi_nib <= d_q;
                    hi_rs  <= rs_q;
                    phase  <= PH_LOW;
                end else begin
                    phase <= PH_HIGH;
                end
            end
        end
    end

    always_ff @(posedge clkLcd or posedge reset) begin
        if (reset) begin
            byte_valid <= 1'b0;
            byte_rs    <= 1'b0;
            byte_data  <= '0;
            cur_addr   <= '0;
            busy       <= 1'b0;
            sweep_idx  <= '0;
            overrun    <= 1'b0;
        end else begin
            byte_valid <= comp_valid;
            if (comp_valid) begin
                byte_rs   <= comp_rs;
                byte_data <= comp_byte;
            end
            if (busy) begin
                sweep_idx <= sweep_idx + 5'd1;
                if (sweep_idx == 5'd31)
                    busy <= 1'b0;
            end
            if (comp_valid) begin
                if (busy) begin
                    overrun <= 1'b1;
                end else if (comp_rs) begin
                    cur_addr <= {cur_addr[4], cur_addr[3:0] + 4'd1};
                end else if (comp_byte[7]) begin
                    cur_addr <= {comp_byte[6], comp_byte[3:0]};
                end else if (comp_byte == 8'h01) begin
                    busy      <= 1'b1;
                    sweep_idx <= '0;
                    cur_addr  <= '0;
                end else if (comp_byte == 8'h02 || comp_byte == 8'h03) begin
                    cur_addr <= '0;
                end
            end
        end
    end

    // The sweep owns the write port; byte application is blocked while busy.
    always_ff @(posedge clkLcd or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++)
                disp_buf[i] <= 8'h20;
            rd_data <= '0;
        end else begin
            rd_data <= disp_buf[rd_addr];
            if (busy)
                disp_buf[sweep_idx] <= 8'h20;
            else if (comp_valid && comp_rs)
                disp_buf[cur_addr] <= comp_byte;
        end
    end

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Scoreboard bench for lcd_nibble_receiver: expected bytes are queued at stimulus time
// and a monitor pops them on every byte_valid pulse; state is checked directly.
module tb_lcd_nibble_receiver;

    logic       clkLcd = 1'b0;
    logic       reset;
    logic       lcd_rs;
    logic       lcd_e;
    logic [3:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       byte_valid;
    logic       byte_rs;
    logic [7:0] byte_data;
    logic       mode4;
    logic       busy;
    logic [4:0] cur_addr;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic [8:0] exp_q [$];

    always #5 clkLcd = ~clkLcd;

    lcd_nibble_receiver dut (
        .clkLcd(clkLcd), .reset(reset), .lcd_rs(lcd_rs), .lcd_e(lcd_e),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data),
        .mode4(mode4), .busy(busy), .cur_addr(cur_addr), .overrun(overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every byte_valid pulse must match the head of the scoreboard.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clkLcd);
            if (byte_valid === 1'b1) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {23'd0, byte_rs, byte_data}, 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_out", {23'd0, byte_rs, byte_data}, {23'd0, e});
                end
            end
        end
    end

    task automatic send_nib(input logic rs, input logic [3:0] nib, input int hold);
        @(negedge clkLcd);
        lcd_rs   = rs;
        lcd_data = nib;
        lcd_e    = 1'b1;
        repeat (hold) @(negedge clkLcd);
        lcd_e = 1'b0;
        @(negedge clkLcd);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b});
        send_nib(rs, b[7:4], 1);
        send_nib(rs, b[3:0], 1);
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] exp);
        @(negedge clkLcd);
        rd_addr = a;
        @(negedge clkLcd);
        chk($sformatf("rd_data[%0d]", a), {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clkLcd);
            n++;
        end
        if (n >= 200) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int bcnt;
        int p0;
        reset = 1'b1; lcd_rs = 1'b0; lcd_e = 1'b0; lcd_data = '0; rd_addr = '0;
        repeat (3) @(negedge clkLcd);
        chk("rst_mode4", {31'd0, mode4}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cur_addr", {27'd0, cur_addr}, 32'd0);
        chk("rst_outputs", {22'd0, byte_valid, byte_rs, byte_data}, 32'd0);
        chk("rst_overrun_rd", {23'd0, overrun, rd_data}, 32'd0);
        reset = 1'b0;
        rd(5'd5, 8'h20);

        // Init sequence in 8-bit mode
        exp_q.push_back({1'b0, 8'h30}); send_nib(1'b0, 4'h3, 1);
        exp_q.push_back({1'b0, 8'h30}); send_nib(1'b0, 4'h3, 1);
        exp_q.push_back({1'b0, 8'h30}); send_nib(1'b0, 4'h3, 1);
        chk("mode4_before", {31'd0, mode4}, 32'd0);
        exp_q.push_back({1'b0, 8'h20}); send_nib(1'b0, 4'h2, 1);
        chk("mode4_after", {31'd0, mode4}, 32'd1);

        send_byte(1'b0, 8'hC0);
        chk("addr_C0", {27'd0, cur_addr}, 32'h10);
        send_byte(1'b1, 8'h41);
        chk("addr_A", {27'd0, cur_addr}, 32'h11);
        send_byte(1'b1, 8'h42);
        chk("addr_B", {27'd0, cur_addr}, 32'h12);
        rd(5'd16, 8'h41);
        rd(5'd17, 8'h42);

        // Column wrap stays in row 0
        send_byte(1'b0, 8'h8F);
        send_byte(1'b1, 8'h5A);
        send_byte(1'b1, 8'h5B);
        chk("addr_wrap", {27'd0, cur_addr}, 32'h01);
        rd(5'd15, 8'h5A);
        rd(5'd0, 8'h5B);

        // Strobe timing with a long E pulse
        exp_q.push_back({1'b1, 8'h43});
        p0 = pulses;
        send_nib(1'b1, 4'h4, 10);
        chk("no_valid_high", {31'd0, byte_valid}, 32'd0);
        send_nib(1'b1, 4'h3, 10);
        chk("valid_low", {31'd0, byte_valid}, 32'd1);
        @(negedge clkLcd);
        chk("single_pulse", pulses - p0, 32'd1);
        rd(5'd1, 8'h43);
        chk("addr_43", {27'd0, cur_addr}, 32'h02);

        send_byte(1'b0, 8'h02);
        chk("addr_home", {27'd0, cur_addr}, 32'h00);
        send_byte(1'b0, 8'hD5);
        chk("addr_D5", {27'd0, cur_addr}, 32'h15);
        send_byte(1'b0, 8'h3A);
        chk("addr_noop", {27'd0, cur_addr}, 32'h15);

        // Clear sweep length and contents
        send_byte(1'b0, 8'h01);
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 100) begin
            bcnt++;
            @(negedge clkLcd);
        end
        chk("busy_cycles", bcnt, 32'd32);
        chk("addr_clear", {27'd0, cur_addr}, 32'd0);
        chk("overrun_clean", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 32; i++) rd(5'(i), 8'h20);

        // Data during a sweep: emitted, not applied, overrun set
        send_byte(1'b0, 8'h01);
        send_byte(1'b1, 8'h58);
        chk("busy_during", {31'd0, busy}, 32'd1);
        wait_idle();
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        chk("addr_after_ovr", {27'd0, cur_addr}, 32'd0);
        rd(5'd0, 8'h20);
        rd(5'd1, 8'h20);

        // Reset mid-byte drops the high nibble and mode4
        send_nib(1'b1, 4'h4, 1);
        @(negedge clkLcd); reset = 1'b1;
        @(negedge clkLcd);
        chk("rst2_mode4", {31'd0, mode4}, 32'd0);
        chk("rst2_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        exp_q.push_back({1'b0, 8'h20});
        send_nib(1'b0, 4'h2, 1);
        chk("rst2_mode4_set", {31'd0, mode4}, 32'd1);

        repeat (3) @(negedge clkLcd);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lcd_nibble_receiver.md
LCD_NIBBLE_RECEIVER -- requirements
Module: lcd_nibble_receiver

Interface
REQ-001 SHALL: clock clkLcd; reset reset, asynchronous, active-high.
REQ-002 SHALL have these ports:
- clkLcd  in  1  clock; all state on rising edge
- reset  in  1  async active-high reset
- lcd_rs  in  1  HD44780 register select; 0 = command, 1 = data
- lcd_e  in  1  HD44780 enable strobe
- lcd_data  in  4  HD44780 DB7..DB4 nibble
- rd_addr  in  5  buffer read address; [4] = row, [3:0] = column
- rd_data  out  8  buffer byte at rd_addr, registered
- byte_valid  out  1  one-cycle pulse when a byte completes
- byte_rs  out  1  RS of completed byte
- byte_data  out  8  completed byte
- mode4  out  1  1 once 4-bit mode is established
- busy  out  1  clear-display sweep in progress
- cur_addr  out  5  current write address, same encoding as rd_addr
- overrun  out  1  sticky; byte arrived while busy

Function
REQ-003 SHALL register lcd_e, lcd_rs and lcd_data every cycle into e_q, rs_q and d_q.
REQ-004 SHALL detect a strobe when e_q=1 and lcd_e=0, and capture rs_q/d_q at that edge; no other lcd_e activity has any effect.
REQ-005 SHALL hold the 32x8 display buffer in flops; row r, column c is at index {r,c}.
REQ-006 INIT8 mode (mode4=0): each strobe completes byte {nibble,4'h0} with its RS.
REQ-007 In INIT8, a strobe with rs=0 and nibble 4'h2 SHALL set mode4=1 after emitting that byte; the high/low phase SHALL be set to HIGH.
REQ-008 4-bit mode: the first strobe stores the high nibble and its RS; the second strobe completes {high,low} using the RS latched with the high nibble; the phase then returns to HIGH.
REQ-009 Latency: byte_valid, byte_rs and byte_data SHALL assert on the cycle after the completing strobe is detected; byte_valid lasts exactly 1 cycle; byte_rs/byte_data hold until the next byte.
REQ-010 Completed byte with rs=1 and busy=0: buffer[cur_addr] <= byte; cur_addr column +1, wrapping 15->0 within the same row; the row is never changed.
REQ-011 Command 8'h01: start a clear sweep; busy=1 for exactly 32 cycles, writing 8'h20 to indices 0..31 in order; afterwards cur_addr=0 and busy=0.
REQ-012 Command 8'h02 or 8'h03: cur_addr <= 0; buffer unchanged.
REQ-013 Command with bit7=1: cur_addr <= {byte[6], byte[3:0]}; bits 5:4 ignored.
REQ-014 Commands 8'h04..8'h7F and 8'h00: emitted on byte_valid only; no state change.
REQ-015 A byte completing while busy=1 SHALL still be emitted on byte_valid, but SHALL NOT be applied, and SHALL set overrun=1; only reset clears overrun.
REQ-016 rd_data SHALL equal buffer[rd_addr] as sampled one cycle earlier (1-cycle read latency); a simultaneous write to the same index SHALL return the old value.
REQ-017 Nibble assembly SHALL continue while busy; only byte application is blocked.
REQ-018 In INIT8, a completing rs=1 byte SHALL write to the buffer per REQ-010.

Reset
REQ-019 On reset: mode4=0, phase=HIGH, cur_addr=0, busy=0, overrun=0, byte_valid=0, byte_rs=0, byte_data=8'h00, rd_data=8'h00, e_q=rs_q=0, d_q=0, and all 32 buffer bytes = 8'h20.
REQ-020 A reset asserted mid-byte or mid-sweep SHALL discard the partial nibble and the sweep; the first strobe after release is treated as INIT8.

Verification
REQ-021 Init sequence: strobes rs=0 with nibbles 3,3,3,2 -> four byte_valid pulses with bytes 30,30,30,20; mode4=1 after the fourth.
REQ-022 After init, send cmd C0 then data "AB" (nibble pairs 4/1, 4/2) -> cur_addr goes 10 then 12; buffer[16]=41 and buffer[17]=42; reading rd_addr=16 gives rd_data=41 one cycle later.
REQ-023 Column wrap: cmd 8F, data 5A, data 5B -> buffer[15]=5A, buffer[0]=5B, cur_addr=01.
REQ-024 Clear: cmd 01 -> busy high exactly 32 cycles; all entries 20; cur_addr=0. A data byte 58 completed during the sweep -> byte_valid pulses, buffer unchanged, overrun=1.
REQ-025 Strobe timing: first strobe detected at cycle t -> no byte_valid at t+1; second strobe detected at cycle t+k -> byte_valid exactly at t+k+1; holding lcd_e high for 10 cycles produces a single strobe.
REQ-026 Reset after a high nibble only, in 4-bit mode -> mode4=0; the next strobe with nibble 2 emits byte 20 and sets mode4=1.
